mem_req_cp4: RTL and testbench

- Data-memory request stage of the cp4 RISC-V core. Sits between the execute/memory pipeline stage and the load masking stage.
- Accepts one load or store per handshake and drives word-aligned data-memory accesses.
- Stores: generates byte enables and lane-shifted write data.
- Loads: waits a variable number of cycles for read data, then hands raw word, load type and byte offset downstream for masking and sign extension.

---
 rtl/cp4_mem_pkg.sv | 30 +++
 rtl/store_align_cp4.sv | 29 ++
 rtl/mem_req_cp4.sv | 133 +++++++++++++
 tb/tb_mem_req_cp4.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp4_mem_pkg.sv
// Shared definitions for the cp4 data-memory request path: funct3 codes,
// request FSM encoding and the misalignment rule used by the optional check.
package cp4_mem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        WAIT_RD = 1'b1
    } state_t;

    // Halfwords need an even byte offset, words need offset 00; bytes never misalign.
    function automatic logic is_misaligned(input logic       is_store,
                                           input logic [2:0] funct3,
                                           input logic [1:0] off);
        logic half;
        logic word;
        half = is_store ? (funct3 == SH) : ((funct3 == LH) || (funct3 == LHU));
        word = is_store ? (funct3 == SW) : (funct3 == LW);
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

endpackage

// File: rtl/store_align_cp4.sv
// Store lane steering: funct3 + byte offset + right-aligned rs2 data become
// per-byte write enables and lane-replicated write data (purely combinational).
module store_align_cp4
    import cp4_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] data
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);

            // Replicating the narrow value into every lane lets the enables alone select the target bytes.
            assign be[gi] = (funct3 == SB) ? (off == LANE) :
                            (funct3 == SH) ? (off[1] == LANE[1]) :
                            (funct3 == SW);

            assign data[gi*8 +: 8] = (funct3 == SB) ? wdata[7:0] :
                                     (funct3 == SH) ? wdata[(gi % 2)*8 +: 8] :
                                                      wdata[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_req_cp4.sv
// cp4 data-memory request stage: issues word-aligned loads/stores and waits
// for load data with a bounded timeout. Optional misalignment trap: MEM_REQ_MISALIGN_EN.
module mem_req_cp4
    import cp4_mem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              dmem_en,
    output logic [3:0]        dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              ld_valid,
    output logic [31:0]       ld_data,
    output logic [2:0]        ld_type,
    output logic [1:0]        ld_byte_offset,
    output logic              err_timeout,
    output logic              err_misalign
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       pend_type_reg;
    logic [1:0]       pend_off_reg;

    logic             accept;
    logic             misalign_hit;
    logic [3:0]       st_be;
    logic [31:0]      st_data;

    assign req_ready = (state_reg == IDLE);
    assign accept    = req_valid & req_ready;

    store_align_cp4 u_store_align (
        .funct3 (req_funct3),
        .off    (req_addr[1:0]),
        .wdata  (req_wdata),
        .be     (st_be),
        .data   (st_data)
    );

`ifdef MEM_REQ_MISALIGN_EN
    assign misalign_hit = is_misaligned(req_is_store, req_funct3, req_addr[1:0]);
`else
    // Misaligned ops are issued as-is; the lane rules truncate the offset.
    assign misalign_hit = 1'b0;
    assign err_misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            pend_type_reg  <= '0;
            pend_off_reg   <= '0;
            dmem_en        <= 1'b0;
            dmem_we        <= '0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            ld_valid       <= 1'b0;
            ld_data        <= '0;
            ld_type        <= '0;
            ld_byte_offset <= '0;
            err_timeout    <= 1'b0;
`ifdef MEM_REQ_MISALIGN_EN
            err_misalign   <= 1'b0;
`endif
        end else begin
            // Strobes and pulses default low so every issue/result lasts one cycle.
            dmem_en     <= 1'b0;
            dmem_we     <= '0;
            ld_valid    <= 1'b0;
            err_timeout <= 1'b0;
`ifdef MEM_REQ_MISALIGN_EN
            err_misalign <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (misalign_hit) begin
`ifdef MEM_REQ_MISALIGN_EN
                            err_misalign <= 1'b1;
`endif
                        end else begin
                            dmem_en   <= 1'b1;
                            dmem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (req_is_store) begin
                                dmem_we    <= st_be;
                                dmem_wdata <= st_data;
                            end else begin
                                state_reg     <= WAIT_RD;
                                cnt_reg       <= '0;
                                pend_type_reg <= req_funct3;
                                pend_off_reg  <= req_addr[1:0];
                            end
                        end
                    end
                end

                WAIT_RD: begin
                    // Data arriving on the final wait cycle still wins over the timeout.
                    if (dmem_rvalid) begin
                        ld_valid       <= 1'b1;
                        ld_data        <= dmem_rdata;
                        ld_type        <= pend_type_reg;
                        ld_byte_offset <= pend_off_reg;
                        state_reg      <= IDLE;
                    end else if (cnt_reg == CNT_W'(MAX_WAIT - 1)) begin
                        err_timeout <= 1'b1;
                        state_reg   <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_cp4.sv
// Self-checking bench for mem_req_cp4: directed literal cases followed by random
// traffic, all compared every cycle against a transaction-level model.
module tb_mem_req_cp4;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        dmem_en;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [2:0]  ld_type;
    logic [1:0]  ld_byte_offset;
    logic        err_timeout;
    logic        err_misalign;

    int n_chk  = 0;
    int n_fail = 0;

    mem_req_cp4 #(.ADDR_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_store   (req_is_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .dmem_en        (dmem_en),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .ld_valid       (ld_valid),
        .ld_data        (ld_data),
        .ld_type        (ld_type),
        .ld_byte_offset (ld_byte_offset),
        .err_timeout    (err_timeout),
        .err_misalign   (err_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding load at most, counted in whole wait cycles.
    function automatic bit model_misaligned(input bit st, input bit [2:0] f3, input bit [1:0] off);
`ifdef MEM_REQ_MISALIGN_EN
        bit half;
        bit word;
        half = st ? (f3 == 3'd1) : (f3 == 3'd1 || f3 == 3'd5);
        word = (f3 == 3'd2);
        return (half && off[0] == 1'b1) || (word && off != 2'd0);
`else
        return (st && f3 == 3'd7 && off == 2'd3) && 1'b0;
`endif
    endfunction

    bit        m_busy = 0;
    int        m_wait = 0;
    bit [2:0]  p_f3 = 0;
    bit [1:0]  p_off = 0;
    bit        e_en = 0, e_store = 0, e_ldv = 0, e_to = 0, e_mis = 0;
    bit [3:0]  e_we = 0;
    bit [31:0] e_addr = 0, e_wdata = 0, e_ldd = 0;
    bit [2:0]  e_type = 0;
    bit [1:0]  e_off = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 0; m_wait = 0;
            e_en = 0; e_store = 0; e_ldv = 0; e_to = 0; e_mis = 0;
            e_we = 0; e_addr = 0; e_wdata = 0; e_ldd = 0; e_type = 0; e_off = 0;
        end else begin
            e_en = 0; e_we = 0; e_ldv = 0; e_to = 0; e_mis = 0;
            if (!m_busy) begin
                if (req_valid) begin
                    if (model_misaligned(req_is_store, req_funct3, req_addr[1:0])) begin
                        e_mis = 1;
                    end else begin
                        e_en    = 1;
                        e_addr  = req_addr & 32'hFFFF_FFFC;
                        e_store = req_is_store;
                        if (req_is_store) begin
                            case (req_funct3)
                                3'd0: begin e_we = 4'(1 << req_addr[1:0]); e_wdata = 32'(req_wdata[7:0]) * 32'h0101_0101; end
                                3'd1: begin e_we = req_addr[1] ? 4'hC : 4'h3; e_wdata = 32'(req_wdata[15:0]) * 32'h0001_0001; end
                                3'd2: begin e_we = 4'hF; e_wdata = req_wdata; end
                                default: e_we = 4'h0;
                            endcase
                        end else begin
                            m_busy = 1; m_wait = 0;
                            p_f3 = req_funct3; p_off = req_addr[1:0];
                        end
                    end
                    $display("txn t=%0t %s f3=%0d addr=0x%08h wdata=0x%08h%s", $time,
                             req_is_store ? "ST" : "LD", req_funct3, req_addr, req_wdata,
                             e_mis ? " misaligned" : "");
                end
            end else if (dmem_rvalid) begin
                e_ldv = 1; e_ldd = dmem_rdata; e_type = p_f3; e_off = p_off;
                m_busy = 0;
            end else begin
                m_wait++;
                if (m_wait == MAX_WAIT) begin
                    e_to = 1; m_busy = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(!m_busy));
        chk("dmem_en", 32'(dmem_en), 32'(e_en));
        chk("dmem_we", 32'(dmem_we), 32'(e_we));
        if (e_en) chk("dmem_addr", dmem_addr, e_addr);
        if (e_en && e_store && e_we != 0) chk("dmem_wdata", dmem_wdata, e_wdata);
        chk("ld_valid", 32'(ld_valid), 32'(e_ldv));
        if (e_ldv) begin
            chk("ld_data", ld_data, e_ldd);
            chk("ld_type", 32'(ld_type), 32'(e_type));
            chk("ld_byte_offset", 32'(ld_byte_offset), 32'(e_off));
        end
        chk("err_timeout", 32'(err_timeout), 32'(e_to));
        chk("err_misalign", 32'(err_misalign), 32'(e_mis));
    end

    task automatic issue(input bit st, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd);
        req_valid = 1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dmem_en"}, 32'(dmem_en), 0);
        chk({tag, "_dmem_we"}, 32'(dmem_we), 0);
        chk({tag, "_dmem_addr"}, dmem_addr, 0);
        chk({tag, "_dmem_wdata"}, dmem_wdata, 0);
        chk({tag, "_ld_valid"}, 32'(ld_valid), 0);
        chk({tag, "_ld_data"}, ld_data, 0);
        chk({tag, "_ld_type"}, 32'(ld_type), 0);
        chk({tag, "_ld_off"}, 32'(ld_byte_offset), 0);
        chk({tag, "_err_timeout"}, 32'(err_timeout), 0);
        chk({tag, "_err_misalign"}, 32'(err_misalign), 0);
        chk({tag, "_req_ready"}, 32'(req_ready), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1;

        // SB to the top byte lane
        issue(1, 3'd0, 32'h0000_1003, 32'h0000_00AB);
        @(negedge clk);
        chk("sb_en", 32'(dmem_en), 1);
        chk("sb_addr", dmem_addr, 32'h0000_1000);
        chk("sb_we", 32'(dmem_we), 32'h8);
        chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);

        // SH upper half, then SW in the following cycle
        issue(1, 3'd1, 32'h0000_2002, 32'h0000_1234);
        @(negedge clk);
        chk("sh_we", 32'(dmem_we), 32'hC);
        chk("sh_wdata", dmem_wdata, 32'h1234_1234);
        issue(1, 3'd2, 32'h0000_2000, 32'hCAFE_F00D);
        @(negedge clk);
        chk("sw_we", 32'(dmem_we), 32'hF);
        chk("sw_wdata", dmem_wdata, 32'hCAFE_F00D);

        // Unknown store funct3: strobe without enables
        issue(1, 3'd3, 32'h0000_6000, 32'h1111_2222);
        @(negedge clk);
        chk("st_unk_en", 32'(dmem_en), 1);
        chk("st_unk_we", 32'(dmem_we), 0);

        // LBU, rvalid four cycles after dmem_en
        issue(0, 3'd4, 32'h0000_3001, 32'h0);
        @(negedge clk);
        chk("lbu_en", 32'(dmem_en), 1);
        chk("lbu_we", 32'(dmem_we), 0);
        chk("lbu_addr", dmem_addr, 32'h0000_3000);
        chk("lbu_ready_c1", 32'(req_ready), 0);
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("lbu_ready_wait", 32'(req_ready), 0);
            chk("lbu_ldv_wait", 32'(ld_valid), 0);
        end
        @(posedge clk); #1;
        dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        dmem_rvalid = 0;
        @(negedge clk);
        chk("lbu_ldv", 32'(ld_valid), 1);
        chk("lbu_data", ld_data, 32'hDEAD_BEEF);
        chk("lbu_type", 32'(ld_type), 32'h4);
        chk("lbu_off", 32'(ld_byte_offset), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lbu_ldv_pulse", 32'(ld_valid), 0);

        // LW timeout, then a stray rvalid
        issue(0, 3'd2, 32'h0000_5000, 32'h0);
        for (int i = 0; i < MAX_WAIT; i++) begin
            @(negedge clk);
            chk("to_wait_ready", 32'(req_ready), 0);
            chk("to_wait_err", 32'(err_timeout), 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_err", 32'(err_timeout), 1);
        chk("to_ldv", 32'(ld_valid), 0);
        chk("to_ready", 32'(req_ready), 1);
        @(posedge clk); #1;
        dmem_rvalid = 1; dmem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("to_err_pulse", 32'(err_timeout), 0);
        @(posedge clk); #1;
        dmem_rvalid = 0;
        @(negedge clk);
        chk("stray_ldv", 32'(ld_valid), 0);

        // rvalid on the last wait cycle: data wins
        issue(0, 3'd2, 32'h0000_7004, 32'h0);
        repeat (MAX_WAIT - 1) begin
            @(posedge clk); #1;
        end
        dmem_rvalid = 1; dmem_rdata = 32'h0BAD_CAFE;
        @(posedge clk); #1;
        dmem_rvalid = 0;
        @(negedge clk);
        chk("edge_ldv", 32'(ld_valid), 1);
        chk("edge_to", 32'(err_timeout), 0);
        chk("edge_data", ld_data, 32'h0BAD_CAFE);

        // Reset during WAIT_RD abandons the load
        issue(0, 3'd0, 32'h0000_8002, 32'h0);
        @(posedge clk); #1;
        rst_n = 0;
        @(negedge clk);
        chk_all_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1;
        dmem_rvalid = 1; dmem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        dmem_rvalid = 0;
        @(negedge clk);
        chk("midrst_ldv", 32'(ld_valid), 0);
        chk("midrst_ready", 32'(req_ready), 1);

        // Misaligned word load
        issue(0, 3'd2, 32'h0000_4002, 32'h0);
        @(negedge clk);
`ifdef MEM_REQ_MISALIGN_EN
        chk("mis_err", 32'(err_misalign), 1);
        chk("mis_en", 32'(dmem_en), 0);
        chk("mis_ready", 32'(req_ready), 1);
`else
        chk("mis_err", 32'(err_misalign), 0);
        chk("mis_en", 32'(dmem_en), 1);
        chk("mis_addr", dmem_addr, 32'h0000_4000);
        for (int i = 0; i < 2 * MAX_WAIT && !req_ready; i++) begin
            @(posedge clk); #1;
            dmem_rvalid = 1;
        end
        @(posedge clk); #1;
        dmem_rvalid = 0;
`endif

        // Random traffic
        repeat (1500) begin
            @(posedge clk); #1;
            req_valid    = ($urandom_range(0, 1) == 1);
            req_is_store = ($urandom_range(0, 1) == 1);
            req_funct3   = 3'($urandom_range(0, 7));
            req_addr     = $urandom;
            req_wdata    = $urandom;
            dmem_rvalid  = ($urandom_range(0, 3) == 0);
            dmem_rdata   = $urandom;
        end
        @(posedge clk); #1;
        req_valid = 0; dmem_rvalid = 0;
        repeat (MAX_WAIT + 3) @(posedge clk);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
